// File: rtl/div_if.sv
// Request/response bundle for div_unit: request handshake, flush, and result handshake.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             i_ready;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_flush;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_result;

  modport master (
    output i_valid, i_op, i_a, i_b, i_flush, o_ready,
    input  i_ready, o_valid, o_result
  );

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_flush, o_ready,
    output i_ready, o_valid, o_result
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per clock.
// Optional macro DIV_EARLY_OUT_EN finishes in one edge when |a| < |b|.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [5:0] LAST_CNT = 6'(WIDTH);

  logic [1:0]       state_q;
  logic [5:0]       cnt_q;
  logic [1:0]       op_q;
  logic             a_neg_q;
  logic             b_neg_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             sub_ok;
  logic             early_out;
  logic             a_is_signed;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] x,
                                               input logic is_signed);
    abs_mag = (is_signed && x[WIDTH-1]) ? WIDTH'(-x) : WIDTH'(x);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic neg);
    apply_sign = neg ? (~mag + 1'b1) : mag;
  endfunction

  assign a_s         = bus.i_a;
  assign b_s         = bus.i_b;
  assign a_is_signed = ~bus.i_op[0];

  // Partial remainder shifted left with the next dividend bit, then trial subtract
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, div_q};
  assign sub_ok  = ~rem_sub[WIDTH];

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (quo_q < div_q);
`else
  assign early_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      result_q <= '0;
    end else if (bus.i_flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_valid) begin
            op_q    <= bus.i_op;
            a_neg_q <= a_is_signed & bus.i_a[WIDTH-1];
            b_neg_q <= a_is_signed & bus.i_b[WIDTH-1];
            quo_q   <= abs_mag(a_s, a_is_signed);
            div_q   <= abs_mag(b_s, a_is_signed);
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          // On the first edge quo_q still holds |a|, so re-signing it restores the raw dividend
          if (cnt_q == 6'd0 && div_q == '0) begin
            result_q <= op_q[1] ? apply_sign(quo_q, a_neg_q) : '1;
            state_q  <= S_DONE;
          end else if (cnt_q == 6'd0 && early_out) begin
            result_q <= op_q[1] ? apply_sign(quo_q, a_neg_q) : '0;
            state_q  <= S_DONE;
          end else if (cnt_q == LAST_CNT) begin
            result_q <= op_q[1] ? apply_sign(rem_q, a_neg_q)
                                : apply_sign(quo_q, a_neg_q ^ b_neg_q);
            state_q  <= S_DONE;
          end else begin
            quo_q <= {quo_q[WIDTH-2:0], sub_ok};
            rem_q <= sub_ok ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_DONE: begin
          if (bus.o_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.i_ready  = (state_q == S_IDLE);
  assign bus.o_valid  = (state_q == S_DONE);
  assign bus.o_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized ops vs. an arithmetic model.
`timescale 1ns/1ps
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  div_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'b00:   return ovf ? 32'h8000_0000 : 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return ovf ? 32'd0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    ma = (!op[0] && a[31]) ? -a : a;
    mb = (!op[0] && b[31]) ? -b : b;
    if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    if (ma == mb) return 33;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'($urandom_range(0, 20));
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    bus.o_ready = 1'b0;
    bus.i_op    = 2'b00;
    bus.i_a     = '0;
    bus.i_b     = '0;
  endtask

  // Issue one request, measure latency, check result, hold, then consume
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int          exp_lat;
    int          lat;
    exp     = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    @(negedge clk);
    check({tag, "_rdy"}, 32'(bus.i_ready), 32'd1);
    bus.i_valid = 1'b1;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_op    = 2'($urandom);
    bus.i_a     = $urandom;
    bus.i_b     = $urandom;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.o_valid) begin
        lat = n;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (lat == 0) begin
      @(negedge clk); bus.i_flush = 1'b1;
      @(negedge clk); bus.i_flush = 1'b0;
      return;
    end
    check({tag, "_res"}, bus.o_result, exp);
    check({tag, "_rdy_done"}, 32'(bus.i_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold_vld"}, 32'(bus.o_valid), 32'd1);
      check({tag, "_hold_res"}, bus.o_result, exp);
    end
    @(negedge clk); bus.o_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_consumed"}, 32'(bus.o_valid), 32'd0);
    @(negedge clk); bus.o_ready = 1'b0;
  endtask

  // Accept a request and advance to just before edge E<n> of the calculation
  task automatic start_and_run(input logic [31:0] a, input logic [31:0] b, input int n);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_op    = 2'b01;
    bus.i_a     = a;
    bus.i_b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        seen;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("reset_irdy", 32'(bus.i_ready), 32'd1);
    check("reset_ovld", 32'(bus.o_valid), 32'd0);
    check("reset_res",  bus.o_result, 32'd0);

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5);
    do_op("div_m7_2",   2'b00, -32'd7, 32'd2, 1);
    do_op("rem_m7_2",   2'b10, -32'd7, 32'd2, 1);
    do_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    do_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    do_op("div_5_0",    2'b00, 32'd5, 32'd0, 1);
    do_op("remu_5_0",   2'b11, 32'd5, 32'd0, 1);
    do_op("rem_m5_0",   2'b10, -32'd5, 32'd0, 1);
    do_op("divu_3_10",  2'b01, 32'd3, 32'd10, 1);
    do_op("rem_7_m2",   2'b10, 32'd7, -32'd2, 0);

    // Flush sampled on E10 of the calculation
    start_and_run(32'd1000, 32'd3, 10);
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    check("flush_irdy", 32'(bus.i_ready), 32'd1);
    check("flush_ovld", 32'(bus.o_valid), 32'd0);
    @(negedge clk); bus.i_flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.o_valid) seen = 1'b1;
    end
    check("flush_no_result", 32'(seen), 32'd0);
    do_op("divu_9_3", 2'b01, 32'd9, 32'd3, 1);

    // Flush overrides acceptance in IDLE
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_flush = 1'b1; bus.i_op = 2'b01; bus.i_a = 32'd8; bus.i_b = 32'd0;
    @(posedge clk); #1;
    check("flush_idle_irdy", 32'(bus.i_ready), 32'd1);
    @(negedge clk); bus.i_valid = 1'b0; bus.i_flush = 1'b0;
    @(posedge clk); #1;
    check("flush_idle_ovld", 32'(bus.o_valid), 32'd0);

    // Reset on E20 of the calculation, with a nonzero result left from before
    start_and_run(32'd77777, 32'd5, 20);
    rst = 1'b1;
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ovld", 32'(bus.o_valid), 32'd0);
    check("rst_mid_res",  bus.o_result, 32'd0);
    check("rst_mid_irdy", 32'(bus.i_ready), 32'd1);
    @(negedge clk); rst = 1'b0; bus.i_flush = 1'b0;

    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      do_op("rand", op, a, b, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
